int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Interrupt controller directly upstream of the MIPS core; drives the core's `int_occured`/`int_pc` inputs and consumes its `available_for_int` output.
- Edge-detects NUM_IRQ external request lines into a pending register and masks them.
- Picks the highest-priority enabled pending request and presents it to the core as a fixed-length pulse with a computed 10-bit vector PC.
- Holds off further dispatches until software signals end-of-interrupt.

Parameters:
- NUM_IRQ, 4, number of request sources (2..8)
- VEC_BASE, 38, int_pc of source 0
- VEC_STRIDE, 4, int_pc spacing between consecutive sources
- PULSE_CYCLES, 2, cycles `int_occured` is held high per dispatch (>=1)
- MASK_RESET, all ones, mask value after reset (1 = enabled)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- irq_in  in  NUM_IRQ  request lines, synchronous to clk, level; rising edge = request
- available_for_int  in  1  core can accept an interrupt this cycle
- eoi  in  1  end-of-interrupt pulse; releases SERVICE
- mask_we  in  1  mask write enable
- mask_wdata  in  NUM_IRQ  new mask value
- int_occured  out  1  interrupt request to core
- int_pc  out  10  vector PC to core
- irq_id  out  clog2(NUM_IRQ)  index of dispatched/in-service source
- in_service  out  1  high from dispatch until eoi accepted
- pending  out  NUM_IRQ  pending register
- mask  out  NUM_IRQ  mask register

Behaviour:
- Reset (rst high at a clk edge):
  - pending=0, prev_irq=0, mask=MASK_RESET, state=IDLE.
  - int_occured=0, int_pc=0, irq_id=0, in_service=0, pulse counter=0.
  - Reset mid-pulse or mid-service aborts immediately: int_occured is low after that edge.
- Edge detect:
  - prev_irq registers irq_in.
  - Edge on source i = irq_in[i] & ~prev_irq[i]; it sets pending[i] at the same edge.
  - A source held high through reset release counts as one edge on the first post-reset edge.
- Mask: on mask_we, mask <= mask_wdata. A dispatch decision in the same cycle uses the old mask.
- Priority: fixed; lowest index wins among (pending & mask).
- Vector: int_pc = (VEC_BASE + idx*VEC_STRIDE) mod 1024, truncated to 10 bits, no saturation.
- FSM:
  - IDLE
    - If available_for_int and (pending & mask) != 0: latch idx into irq_id, load int_pc, clear pending[idx], counter <= PULSE_CYCLES-1, set int_occured=1 and in_service=1, go to PULSE.
    - Otherwise int_occured=0.
  - PULSE
    - int_occured and int_pc are held.
    - If counter==0: int_occured <= 0, go to SERVICE. Otherwise counter decrements.
    - available_for_int is ignored in this state.
  - SERVICE
    - int_occured=0; int_pc and irq_id are held.
    - On eoi: in_service <= 0, go to IDLE. The earliest next dispatch is the following edge.
    - eoi outside SERVICE is ignored.
- Latency: source sampled high at edge N (low at N-1) → pending set after edge N → int_occured high after edge N+1 (if IDLE and available) → low after edge N+1+PULSE_CYCLES.
- Simultaneous events:
  - Dispatch-clear and a new edge on the same source in the same cycle: the set wins and the request stays pending.
  - An edge on an already-pending source is absorbed; no counting.
  - Masked sources still accumulate pending and dispatch once unmasked.
- No nesting: a higher-priority request arriving in PULSE or SERVICE waits in pending.

Test Plan:
1. Reset check: rst high 2 cycles → int_occured=0, int_pc=0, pending=0, mask=4'b1111, in_service=0; raise rst mid-PULSE → int_occured=0 after that edge.
2. Basic dispatch: available_for_int=1; irq_in[2] rises, sampled at edge 5 → pending=4'b0100 after edge 5; int_occured=1 and int_pc=46 after edges 6–7; low after edge 8; in_service=1 until eoi, then 0.
3. Priority: irq_in[3] and irq_in[1] rise in the same cycle → first dispatch int_pc=42 (irq_id=1); after eoi, second dispatch int_pc=50 (irq_id=3).
4. Masking and availability: mask=4'b1110, irq_in[0] rises → pending[0]=1, no dispatch; then hold available_for_int=0 and write mask=4'b1111 → still no dispatch; set available_for_int=1 → dispatch with int_pc=38 on the next edge.
5. Set-over-clear and wrap: irq_in[0] re-edges in its dispatch cycle → pending[0] stays 1 after dispatch. Second configuration VEC_BASE=1020, VEC_STRIDE=4: source 2 → int_pc=4 (mod 1024).
6. No nesting: irq_in[0] rises during SERVICE of source 3 → int_occured stays 0 until eoi; dispatch of int_pc=38 occurs 1 edge after eoi is accepted.

Source files
------------

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - edge-triggered, maskable, fixed-priority interrupt controller feeding the core
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   irq_in             level request lines; a rising edge latches a pending request
//   available_for_int  core can take an interrupt this cycle
//   eoi                end-of-interrupt pulse, honoured only while servicing
//   mask_we/mask_wdata mask register write port (1 = source enabled)
//   int_occured        interrupt pulse to core, PULSE_CYCLES long per dispatch
//   int_pc             10-bit vector PC of the dispatched source
//   irq_id             index of the dispatched / in-service source
//   in_service         high from dispatch until eoi is accepted
//   pending, mask      live views of the pending and mask registers
module int_ctrl #(
    parameter int                 NUM_IRQ      = 4,
    parameter int                 VEC_BASE     = 38,
    parameter int                 VEC_STRIDE   = 4,
    parameter int                 PULSE_CYCLES = 2,
    parameter logic [NUM_IRQ-1:0] MASK_RESET   = '1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_IRQ-1:0]         irq_in,
    input  logic                       available_for_int,
    input  logic                       eoi,
    input  logic                       mask_we,
    input  logic [NUM_IRQ-1:0]         mask_wdata,
    output logic                       int_occured,
    output logic [9:0]                 int_pc,
    output logic [$clog2(NUM_IRQ)-1:0] irq_id,
    output logic                       in_service,
    output logic [NUM_IRQ-1:0]         pending,
    output logic [NUM_IRQ-1:0]         mask
);

    localparam int IW = $clog2(NUM_IRQ);
    localparam int CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_SERVICE} state_t;

    state_t             state_q;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic               int_occured_q;
    logic [9:0]         int_pc_q;
    logic [IW-1:0]      irq_id_q;
    logic               in_service_q;
    logic [CW-1:0]      cnt_q;

    logic [NUM_IRQ-1:0] req_d;
    logic [NUM_IRQ-1:0] edge_d;
    logic [NUM_IRQ-1:0] clr_d;
    logic [NUM_IRQ-1:0] pending_d;
    logic [IW-1:0]      idx_d;
    logic [9:0]         vec_d;
    logic               dispatch_d;

    always_comb begin
        req_d = pending_q & mask_q;
        // Scan high to low so the lowest set index is the one left standing.
        idx_d = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_d[i]) begin
                idx_d = IW'(i);
            end
        end
        dispatch_d = (state_q == S_IDLE) && available_for_int && (req_d != '0);
        clr_d = '0;
        if (dispatch_d) begin
            clr_d[idx_d] = 1'b1;
        end
        edge_d = irq_in & ~prev_q;
        // A fresh edge beats the dispatch clear so a re-request is never lost.
        pending_d = (pending_q & ~clr_d) | edge_d;
        // Wraps modulo 1024 by plain truncation.
        vec_d = 10'(VEC_BASE + int'(idx_d) * VEC_STRIDE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            prev_q        <= '0;
            pending_q     <= '0;
            mask_q        <= MASK_RESET;
            int_occured_q <= 1'b0;
            int_pc_q      <= '0;
            irq_id_q      <= '0;
            in_service_q  <= 1'b0;
            cnt_q         <= '0;
        end else begin
            prev_q    <= irq_in;
            pending_q <= pending_d;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
            case (state_q)
                S_IDLE: begin
                    int_occured_q <= 1'b0;
                    if (dispatch_d) begin
                        irq_id_q      <= idx_d;
                        int_pc_q      <= vec_d;
                        cnt_q         <= CW'(PULSE_CYCLES - 1);
                        int_occured_q <= 1'b1;
                        in_service_q  <= 1'b1;
                        state_q       <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (cnt_q == '0) begin
                        int_occured_q <= 1'b0;
                        state_q       <= S_SERVICE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_SERVICE: begin
                    int_occured_q <= 1'b0;
                    if (eoi) begin
                        in_service_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    int_occured_q <= 1'b0;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    assign int_occured = int_occured_q;
    assign int_pc      = int_pc_q;
    assign irq_id      = irq_id_q;
    assign in_service  = in_service_q;
    assign pending     = pending_q;
    assign mask        = mask_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - scoreboard bench for int_ctrl
module tb_int_ctrl;

    localparam int PULSE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] irq_in = '0;
    logic       available_for_int = 1'b0;
    logic       eoi = 1'b0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_wdata = '0;

    logic       int_occured;
    logic [9:0] int_pc;
    logic [1:0] irq_id;
    logic       in_service;
    logic [3:0] pending;
    logic [3:0] mask;

    logic       w_occ;
    logic [9:0] w_pc;
    logic [1:0] w_id;
    logic       w_insvc;
    logic [3:0] w_pend;
    logic [3:0] w_mask;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [9:0] pc;
        logic [1:0] id;
    } exp_t;
    exp_t exp_q[$];

    int_ctrl #(.NUM_IRQ(4), .VEC_BASE(38), .VEC_STRIDE(4), .PULSE_CYCLES(PULSE)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .available_for_int(available_for_int),
        .eoi(eoi), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .int_occured(int_occured), .int_pc(int_pc), .irq_id(irq_id),
        .in_service(in_service), .pending(pending), .mask(mask)
    );

    int_ctrl #(.NUM_IRQ(4), .VEC_BASE(1020), .VEC_STRIDE(4), .PULSE_CYCLES(PULSE)) u_wrap (
        .clk(clk), .rst(rst), .irq_in(irq_in), .available_for_int(available_for_int),
        .eoi(eoi), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .int_occured(w_occ), .int_pc(w_pc), .irq_id(w_id),
        .in_service(w_insvc), .pending(w_pend), .mask(w_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [9:0] pc, input logic [1:0] id);
        exp_t e;
        e.pc = pc;
        e.id = id;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per int_occured rising edge, checks pulse width.
    logic occ_prev = 1'b0;
    logic aborted  = 1'b0;
    int   width    = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) aborted = 1'b1;
        if (int_occured && !occ_prev) begin
            width   = 0;
            aborted = rst;
            if (exp_q.size() == 0) begin
                chk("unexpected_dispatch", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_int_pc", int'(int_pc), int'(e.pc));
                chk("sb_irq_id", int'(irq_id), int'(e.id));
            end
        end
        if (int_occured) begin
            width++;
        end else if (occ_prev && !aborted) begin
            chk("pulse_width", width, PULSE);
        end
        occ_prev = int_occured;
    end

    initial begin
        // 1. reset
        tick(2);
        chk("rst_occ", int'(int_occured), 0);
        chk("rst_pc", int'(int_pc), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_mask", int'(mask), 4'b1111);
        chk("rst_insvc", int'(in_service), 0);
        chk("rst_id", int'(irq_id), 0);
        rst = 1'b0;

        // 2. basic dispatch of source 2
        available_for_int = 1'b1;
        irq_in = 4'b0100;
        tick();
        chk("t2_pending", int'(pending), 4'b0100);
        chk("t2_occ_pre", int'(int_occured), 0);
        push(10'd46, 2'd2);
        tick();
        chk("t2_occ1", int'(int_occured), 1);
        chk("t2_pc", int'(int_pc), 46);
        chk("t2_insvc", int'(in_service), 1);
        chk("t2_pend_clr", int'(pending), 0);
        chk("wrap_pc", int'(w_pc), 4);
        tick();
        chk("t2_occ2", int'(int_occured), 1);
        tick();
        chk("t2_occ_low", int'(int_occured), 0);
        chk("t2_insvc_hold", int'(in_service), 1);
        tick(2);
        chk("t2_insvc_wait", int'(in_service), 1);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("t2_insvc_eoi", int'(in_service), 0);
        irq_in = 4'b0000;

        // 3. priority: 1 before 3
        tick();
        irq_in = 4'b1010;
        tick();
        chk("t3_pending", int'(pending), 4'b1010);
        push(10'd42, 2'd1);
        push(10'd50, 2'd3);
        tick();
        chk("t3_id1", int'(irq_id), 1);
        chk("t3_pend_left", int'(pending), 4'b1000);
        tick(2);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        chk("t3_occ_second", int'(int_occured), 1);
        chk("t3_id3", int'(irq_id), 3);
        tick(2);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        irq_in = 4'b0000;

        // 4. masking and availability
        mask_we = 1'b1;
        mask_wdata = 4'b1110;
        tick();
        mask_we = 1'b0;
        chk("t4_mask", int'(mask), 4'b1110);
        irq_in = 4'b0001;
        tick(4);
        chk("t4_masked_occ", int'(int_occured), 0);
        chk("t4_masked_pend", int'(pending), 4'b0001);
        available_for_int = 1'b0;
        mask_we = 1'b1;
        mask_wdata = 4'b1111;
        tick();
        mask_we = 1'b0;
        tick(2);
        chk("t4_unavail_occ", int'(int_occured), 0);
        chk("t4_unavail_pend", int'(pending), 4'b0001);
        push(10'd38, 2'd0);
        available_for_int = 1'b1;
        tick();
        chk("t4_occ", int'(int_occured), 1);
        chk("t4_pc", int'(int_pc), 38);
        tick(2);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        irq_in = 4'b0000;

        // 5. set-over-clear on source 0
        available_for_int = 1'b0;
        tick();
        irq_in = 4'b0001;
        tick();
        irq_in = 4'b0000;
        tick();
        available_for_int = 1'b1;
        irq_in = 4'b0001;
        push(10'd38, 2'd0);
        tick();
        chk("t5_occ", int'(int_occured), 1);
        chk("t5_pend_kept", int'(pending), 4'b0001);
        tick(2);
        push(10'd38, 2'd0);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        chk("t5_redispatch", int'(int_occured), 1);
        chk("t5_pend_clear", int'(pending), 0);
        tick(2);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        irq_in = 4'b0000;
        tick();

        // 6. no nesting; eoi during PULSE ignored
        irq_in = 4'b1000;
        tick();
        push(10'd50, 2'd3);
        tick();
        chk("t6_id3", int'(irq_id), 3);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        chk("t6_insvc_after_pulse_eoi", int'(in_service), 1);
        irq_in = 4'b1001;
        tick();
        chk("t6_pend0", int'(pending), 4'b0001);
        for (int k = 0; k < 3; k++) begin
            chk("t6_no_nest", int'(int_occured), 0);
            tick();
        end
        push(10'd38, 2'd0);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("t6_occ_at_eoi", int'(int_occured), 0);
        chk("t6_insvc_eoi", int'(in_service), 0);
        tick();
        chk("t6_occ_after", int'(int_occured), 1);
        chk("t6_pc", int'(int_pc), 38);
        tick(2);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        irq_in = 4'b0000;
        tick();

        // reset mid-PULSE, then a source held high through reset release
        irq_in = 4'b0100;
        tick();
        push(10'd46, 2'd2);
        tick();
        chk("rp_occ", int'(int_occured), 1);
        rst = 1'b1;
        tick();
        chk("rp_occ_abort", int'(int_occured), 0);
        chk("rp_insvc", int'(in_service), 0);
        chk("rp_pending", int'(pending), 0);
        rst = 1'b0;
        tick();
        chk("rp_held_edge", int'(pending), 4'b0100);
        push(10'd46, 2'd2);
        tick();
        chk("rp_redispatch", int'(int_occured), 1);
        tick(2);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick(3);

        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
